// File: rtl/pkt_id_allocator_pkg.sv
// Shared packet-buffer constants and the allocator state encoding.
package pkt_id_allocator_pkg;

    localparam int PKT_NUM           = 32;  // packet slots in the packet buffer
    localparam int PKT_AWIDTH        = 5;   // packet ID width, 2**PKT_AWIDTH >= PKT_NUM
    localparam int LOW_WM_DEF        = 16;  // default low watermark for ingress backpressure
    localparam int STABLE_CYCLES_DEF = 50;  // default idle cycles after reset before seeding

    typedef enum logic [1:0] {
        ST_WAIT_STABLE = 2'd0,
        ST_INIT        = 2'd1,
        ST_RUN         = 2'd2
    } alloc_state_e;

endpackage

// File: rtl/pkt_id_fifo.sv
// Single-clock circular FIFO of free IDs with a show-ahead output register.
// DEPTH need not be a power of two; pointers wrap DEPTH-1 -> 0.
// count covers the storage array only, not the output register.
module pkt_id_fifo
    import pkt_id_allocator_pkg::*;
#(
    parameter int DEPTH = PKT_NUM,
    parameter int W     = PKT_AWIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         load_en,   // output register may only fill while enabled
    input  logic         rd_ready,
    output logic         rd_valid,
    output logic [W-1:0] rd_data,
    output logic [W:0]   count,
    output logic         full
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_ptr, wr_ptr;
    logic         empty, wr, load;

    function automatic logic [W-1:0] ptr_inc(input logic [W-1:0] p);
        return (p == W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == (W+1)'(DEPTH));
    assign empty = (count == '0);
    assign wr    = wr_en & ~full;
    // Refill when the head is leaving or the output register is empty; a
    // write into an empty array is never forwarded in the same cycle.
    assign load  = load_en & ~empty & (~rd_valid | rd_ready);

    // Storage array, no reset needed: contents are only read behind count.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= wr_data;
    end

    // Pointers, occupancy and the show-ahead output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr)   wr_ptr <= ptr_inc(wr_ptr);
            if (load) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (load) begin
                rd_valid <= 1'b1;
                rd_data  <= mem[rd_ptr];
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pkt_id_allocator.sv
// Packet-buffer ID allocator: seeds the free list after a settle delay,
// serves allocations in FIFO order of return, tracks in-use IDs and flags
// double frees. STABLE_CYCLES must be at least 1.
module pkt_id_allocator
    import pkt_id_allocator_pkg::*;
#(
    parameter int NUM_IDS       = PKT_NUM,
    parameter int ID_WIDTH      = PKT_AWIDTH,
    parameter int LOW_WM        = LOW_WM_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    output logic                alloc_valid,
    output logic [ID_WIDTH-1:0] alloc_data,
    input  logic                alloc_ready,
    input  logic                free_valid,
    input  logic [ID_WIDTH-1:0] free_data,
    output logic                free_ready,
    output logic                init_done,
    output logic [ID_WIDTH:0]   free_count,
    output logic                almost_empty,
    output logic                err_double_free
);

    localparam int SC_W = $clog2(STABLE_CYCLES + 1);

    alloc_state_e        state, state_nxt;
    logic [SC_W-1:0]     stable_cnt;
    logic [ID_WIDTH-1:0] seed_id;
    logic [NUM_IDS-1:0]  in_use;
    logic                seed_wr, run;
    logic                fifo_full, fifo_wr;
    logic [ID_WIDTH-1:0] fifo_wdata;
    logic [ID_WIDTH:0]   fifo_count, fill_nxt;
    logic                alloc_xfer, free_xfer, id_ok, dbl_free, push;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_WAIT_STABLE;
        else     state <= state_nxt;
    end

    // Settle counter and seed ID generator.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_cnt <= '0;
            seed_id    <= '0;
        end else begin
            if (state == ST_WAIT_STABLE) stable_cnt <= stable_cnt + 1'b1;
            if (state == ST_INIT)        seed_id    <= seed_id + 1'b1;
        end
    end

    // Next-state: settle, write one seed per cycle, then run until reset.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT_STABLE: if (stable_cnt == SC_W'(STABLE_CYCLES - 1)) state_nxt = ST_INIT;
            ST_INIT:        if (seed_id == ID_WIDTH'(NUM_IDS - 1))      state_nxt = ST_RUN;
            ST_RUN:         state_nxt = ST_RUN;
            default:        state_nxt = ST_WAIT_STABLE;
        endcase
    end

    // State-decoded controls.
    always_comb begin
        seed_wr    = (state == ST_INIT);
        run        = (state == ST_RUN);
        init_done  = run;
        free_ready = run & ~fifo_full;
    end

    assign alloc_xfer = alloc_valid & alloc_ready;
    assign free_xfer  = free_valid & free_ready;
    // IDs outside the slot range were never handed out, so they count as double frees.
    assign id_ok      = ({1'b0, free_data} < (ID_WIDTH+1)'(NUM_IDS));
    assign dbl_free   = free_xfer & ~(id_ok && in_use[free_data]);
    assign push       = free_xfer & ~dbl_free;

    // Seeding and returned IDs share the write port; they never overlap
    // because free_ready is low outside RUN.
    assign fifo_wr    = seed_wr | push;
    assign fifo_wdata = seed_wr ? seed_id : free_data;

    pkt_id_fifo #(
        .DEPTH (NUM_IDS),
        .W     (ID_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (fifo_wr),
        .wr_data  (fifo_wdata),
        .load_en  (run),
        .rd_ready (alloc_ready),
        .rd_valid (alloc_valid),
        .rd_data  (alloc_data),
        .count    (fifo_count),
        .full     (fifo_full)
    );

    assign free_count = fifo_count + (ID_WIDTH+1)'(alloc_valid);

    // Occupancy after this edge, so the watermark flag moves with free_count.
    always_comb begin
        fill_nxt = free_count;
        if (fifo_wr)    fill_nxt = fill_nxt + 1'b1;
        if (alloc_xfer) fill_nxt = fill_nxt - 1'b1;
    end

    // Registered low-watermark flag.
    always_ff @(posedge clk) begin
        if (rst) almost_empty <= 1'b1;
        else     almost_empty <= (int'(fill_nxt) <= LOW_WM);
    end

    // In-use bitmap: set on allocation, cleared on a legal free. Both can
    // never target the same ID in one cycle, since an ID sitting in the
    // output register is not in use.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_use <= '0;
        end else begin
            if (alloc_xfer) in_use[alloc_data] <= 1'b1;
            if (push)       in_use[free_data]  <= 1'b0;
        end
    end

    // Sticky double-free error.
    always_ff @(posedge clk) begin
        if (rst)           err_double_free <= 1'b0;
        else if (dbl_free) err_double_free <= 1'b1;
    end

endmodule

// File: tb/tb_pkt_id_allocator.sv
// Directed bench for pkt_id_allocator with a non-power-of-2 slot count.
module tb_pkt_id_allocator;

    localparam int NUM_IDS       = 20;
    localparam int ID_WIDTH      = 5;
    localparam int LOW_WM        = 4;
    localparam int STABLE_CYCLES = 50;
    localparam int INIT_LAT      = STABLE_CYCLES + NUM_IDS;

    logic                clk;
    logic                rst;
    logic                alloc_valid;
    logic [ID_WIDTH-1:0] alloc_data;
    logic                alloc_ready;
    logic                free_valid;
    logic [ID_WIDTH-1:0] free_data;
    logic                free_ready;
    logic                init_done;
    logic [ID_WIDTH:0]   free_count;
    logic                almost_empty;
    logic                err_double_free;

    int n_tests = 0;
    int n_fail  = 0;

    pkt_id_allocator #(
        .NUM_IDS       (NUM_IDS),
        .ID_WIDTH      (ID_WIDTH),
        .LOW_WM        (LOW_WM),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_valid     (alloc_valid),
        .alloc_data      (alloc_data),
        .alloc_ready     (alloc_ready),
        .free_valid      (free_valid),
        .free_data       (free_data),
        .free_ready      (free_ready),
        .init_done       (init_done),
        .free_count      (free_count),
        .almost_empty    (almost_empty),
        .err_double_free (err_double_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_alloc_valid"},  int'(alloc_valid), 0);
        chk({pfx, "_alloc_data"},   int'(alloc_data), 0);
        chk({pfx, "_free_ready"},   int'(free_ready), 0);
        chk({pfx, "_init_done"},    int'(init_done), 0);
        chk({pfx, "_free_count"},   int'(free_count), 0);
        chk({pfx, "_almost_empty"}, int'(almost_empty), 1);
        chk({pfx, "_err"},          int'(err_double_free), 0);
    endtask

    // Count edges from reset release until init_done; bounded.
    task automatic wait_init(input string pfx);
        int cyc = 0;
        int busy = 0;
        while (!init_done && cyc < 200) begin
            tick();
            cyc++;
            if (!init_done && (alloc_valid || free_ready)) busy++;
        end
        chk({pfx, "_latency"}, cyc, INIT_LAT);
        chk({pfx, "_quiet"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [ID_WIDTH-1:0] prev;
        int exp_id;

        rst         = 1'b1;
        alloc_ready = 1'b1;
        free_valid  = 1'b0;
        free_data   = '0;
        repeat (3) tick();
        chk_reset("rst0");

        // Seeding, then drain the whole list in ascending order.
        rst = 1'b0;
        wait_init("init0");
        chk("init_fc", int'(free_count), NUM_IDS);
        chk("init_ae", int'(almost_empty), 0);
        chk("init_full_fr", int'(free_ready), 0);
        for (int i = 0; i < NUM_IDS; i++) begin
            tick();
            chk("drain_id", int'(alloc_data), i);
            chk("drain_av", int'(alloc_valid), 1);
            chk("drain_fc", int'(free_count), NUM_IDS - i);
            chk("drain_ae", int'(almost_empty), ((NUM_IDS - i) <= LOW_WM) ? 1 : 0);
        end
        tick();
        chk("drained_av", int'(alloc_valid), 0);
        chk("drained_fc", int'(free_count), 0);
        chk("drained_ae", int'(almost_empty), 1);

        // Free ID 7 into an empty allocator: offered two edges later.
        chk("f7_ready", int'(free_ready), 1);
        free_valid = 1'b1;
        free_data  = 5'd7;
        tick();
        free_valid = 1'b0;
        chk("f7_t1_av", int'(alloc_valid), 0);
        chk("f7_t1_fc", int'(free_count), 1);
        tick();
        chk("f7_t2_av", int'(alloc_valid), 1);
        chk("f7_t2_id", int'(alloc_data), 7);
        chk("f7_t2_fc", int'(free_count), 1);
        tick();
        chk("f7_t3_av", int'(alloc_valid), 0);
        chk("f7_t3_fc", int'(free_count), 0);

        // Double free of ID 5.
        alloc_ready = 1'b0;
        free_valid  = 1'b1;
        free_data   = 5'd5;
        tick();
        chk("df_first_err", int'(err_double_free), 0);
        chk("df_first_fc", int'(free_count), 1);
        tick();
        free_valid = 1'b0;
        chk("df_second_err", int'(err_double_free), 1);
        chk("df_second_fc", int'(free_count), 1);
        repeat (3) tick();
        chk("df_sticky_err", int'(err_double_free), 1);
        chk("df_hold_id", int'(alloc_data), 5);
        chk("df_hold_fc", int'(free_count), 1);

        // Reset while operating: everything forgotten and reseeded.
        rst = 1'b1;
        tick();
        chk_reset("rst1");
        rst         = 1'b0;
        alloc_ready = 1'b1;
        wait_init("init1");

        // Allocate 0..3, then hold 4 while 2 and 0 come back.
        for (int i = 0; i <= 4; i++) begin
            tick();
            chk("pre_hold_id", int'(alloc_data), i);
        end
        alloc_ready = 1'b0;
        free_valid  = 1'b1;
        free_data   = 5'd2;
        tick();
        free_data = 5'd0;
        tick();
        free_valid = 1'b0;
        repeat (5) tick();
        chk("hold_av", int'(alloc_valid), 1);
        chk("hold_id", int'(alloc_data), 4);
        chk("hold_fc", int'(free_count), NUM_IDS - 2);
        chk("hold_err", int'(err_double_free), 0);
        alloc_ready = 1'b1;
        for (int k = 0; k < NUM_IDS - 2; k++) begin
            exp_id = (k < NUM_IDS - 4) ? 4 + k : ((k == NUM_IDS - 4) ? 2 : 0);
            chk("order_id", int'(alloc_data), exp_id);
            chk("order_av", int'(alloc_valid), 1);
            tick();
        end
        chk("order_end_av", int'(alloc_valid), 0);
        chk("order_end_fc", int'(free_count), 0);

        // Keep three IDs in the allocator, then alloc+free every cycle.
        alloc_ready = 1'b0;
        free_valid  = 1'b1;
        free_data   = 5'd10;
        tick();
        free_data = 5'd11;
        tick();
        free_data = 5'd12;
        tick();
        free_valid = 1'b0;
        tick();
        chk("steady_pre_fc", int'(free_count), 3);
        chk("steady_pre_id", int'(alloc_data), 10);
        prev = 5'd0;
        for (int c = 0; c < 100; c++) begin
            alloc_ready = 1'b1;
            free_valid  = 1'b1;
            free_data   = prev;
            chk("steady_av", int'(alloc_valid), 1);
            prev = alloc_data;
            tick();
            chk("steady_fc", int'(free_count), 3);
        end
        chk("steady_err", int'(err_double_free), 0);

        // Free the very ID being allocated this cycle: a double free.
        free_data = alloc_data;
        tick();
        chk("same_cycle_err", int'(err_double_free), 1);
        chk("same_cycle_fc", int'(free_count), 2);

        // Reset mid-stream with inputs still active.
        rst = 1'b1;
        tick();
        chk_reset("rst2");
        rst        = 1'b0;
        free_valid = 1'b0;
        wait_init("init2");
        tick();
        chk("reseed_id0", int'(alloc_data), 0);
        tick();
        chk("reseed_id1", int'(alloc_data), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
